// File: rtl/gshare_pkg.sv
// Shared types for the gshare training path: the update record and the scheduler FSM states.
package gshare_pkg;

   localparam int N = 7;

   typedef struct packed {
      logic         taken;
      logic         mispredicted;
      logic [N-1:0] history;
      logic [N-1:0] pc;
   } train_req_t;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} train_sched_state_t;

endpackage

// File: rtl/gshare_train_fifo.sv
// Circular buffer of training updates: up to two writes (older first) and one read per cycle.
module gshare_train_fifo
   import gshare_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         areset,
   input  logic                         wr0_en_i,
   input  train_req_t                   wr0_data_i,
   input  logic                         wr1_en_i,
   input  train_req_t                   wr1_data_i,
   input  logic                         rd_en_i,
   output train_req_t                   head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   train_req_t    mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wptr_inc;

   assign wptr_inc = wptr_q + PW'(1);

   // A lone port-1 write takes the slot port 0 would have used.
   always_ff @(posedge clk) begin
      if (wr0_en_i)
         mem_q[wptr_q] <= wr0_data_i;
      if (wr1_en_i)
         mem_q[wr0_en_i ? wptr_inc : wptr_q] <= wr1_data_i;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
         rptr_q  <= rptr_q + PW'(rd_en_i);
         count_q <= count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/gshare_train_scheduler.sv
// Funnels two-per-cycle branch resolutions into the single gshare train port, with flush/drain.
// Optional statistics counters are built when GSHARE_TRAIN_STATS_EN is defined.
module gshare_train_scheduler
   import gshare_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic         in0_taken,
   input  logic         in0_mispredicted,
   input  logic [N-1:0] in0_history,
   input  logic [N-1:0] in0_pc,
   input  logic         in1_valid,
   output logic         in1_ready,
   input  logic         in1_taken,
   input  logic         in1_mispredicted,
   input  logic [N-1:0] in1_history,
   input  logic [N-1:0] in1_pc,
   input  logic         train_stall,
   output logic         train_valid,
   output logic         train_taken,
   output logic         train_mispredicted,
   output logic [N-1:0] train_history,
   output logic [N-1:0] train_pc,
   input  logic         flush_req,
   output logic         flush_done,
   output logic         busy
`ifdef GSHARE_TRAIN_STATS_EN
   ,
   output logic [15:0]  stat_updates,
   output logic [15:0]  stat_mispredicts
`endif
);

   localparam int CW = $clog2(DEPTH+1);

   train_sched_state_t state_q;
   train_req_t         in0_req, in1_req, head, out_q;
   logic [CW-1:0]      count;
   logic               out_valid_q, flush_done_q;
   logic               run, enq0, enq1, adv, deq, drain_done;

   assign in0_req = {in0_taken, in0_mispredicted, in0_history, in0_pc};
   assign in1_req = {in1_taken, in1_mispredicted, in1_history, in1_pc};

   // Ready depends only on registered state, never on the valids.
   assign run       = (state_q == RUN);
   assign in0_ready = run && (count <= CW'(DEPTH-1));
   assign in1_ready = run && (count <= CW'(DEPTH-2));
   assign enq0      = in0_valid && in0_ready;
   assign enq1      = in1_valid && in1_ready;

   assign adv        = !out_valid_q || !train_stall;
   assign deq        = adv && (count != '0);
   assign drain_done = adv && (count == '0);

   gshare_train_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .areset     (areset),
      .wr0_en_i   (enq0),
      .wr0_data_i (in0_req),
      .wr1_en_i   (enq1),
      .wr1_data_i (in1_req),
      .rd_en_i    (deq),
      .head_o     (head),
      .count_o    (count)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         out_valid_q <= deq;
         if (deq)
            out_q <= head;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q      <= RUN;
         flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         case (state_q)
            RUN:     if (flush_req) state_q <= DRAIN;
            DRAIN:   if (drain_done) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                     end
            DONE:    state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign train_valid        = out_valid_q;
   assign train_taken        = out_q.taken;
   assign train_mispredicted = out_q.mispredicted;
   assign train_history      = out_q.history;
   assign train_pc           = out_q.pc;
   assign flush_done         = flush_done_q;
   assign busy               = (count != '0) || out_valid_q;

`ifdef GSHARE_TRAIN_STATS_EN
   logic [15:0] stat_updates_q, stat_mispredicts_q;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         stat_updates_q     <= '0;
         stat_mispredicts_q <= '0;
      end else if (out_valid_q && !train_stall) begin
         if (stat_updates_q != 16'hFFFF)
            stat_updates_q <= stat_updates_q + 16'd1;
         if (out_q.mispredicted && (stat_mispredicts_q != 16'hFFFF))
            stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
      end
   end

   assign stat_updates     = stat_updates_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_train_scheduler.sv
// Directed self-checking bench for gshare_train_scheduler; stats checks run when GSHARE_TRAIN_STATS_EN is defined.
module tb_gshare_train_scheduler;

   logic       clk = 1'b0;
   logic       areset;
   logic       in0_valid, in0_taken, in0_mispredicted;
   logic [6:0] in0_history, in0_pc;
   logic       in1_valid, in1_taken, in1_mispredicted;
   logic [6:0] in1_history, in1_pc;
   logic       in0_ready, in1_ready;
   logic       train_stall, train_valid, train_taken, train_mispredicted;
   logic [6:0] train_history, train_pc;
   logic       flush_req, flush_done, busy;
   logic [15:0] out_word;
`ifdef GSHARE_TRAIN_STATS_EN
   logic [15:0] stat_updates, stat_mispredicts;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   bit          new_item;

   always #5 clk = ~clk;

   assign out_word = {train_taken, train_mispredicted, train_history, train_pc};

   gshare_train_scheduler dut (
      .clk                (clk),
      .areset             (areset),
      .in0_valid          (in0_valid),
      .in0_ready          (in0_ready),
      .in0_taken          (in0_taken),
      .in0_mispredicted   (in0_mispredicted),
      .in0_history        (in0_history),
      .in0_pc             (in0_pc),
      .in1_valid          (in1_valid),
      .in1_ready          (in1_ready),
      .in1_taken          (in1_taken),
      .in1_mispredicted   (in1_mispredicted),
      .in1_history        (in1_history),
      .in1_pc             (in1_pc),
      .train_stall        (train_stall),
      .train_valid        (train_valid),
      .train_taken        (train_taken),
      .train_mispredicted (train_mispredicted),
      .train_history      (train_history),
      .train_pc           (train_pc),
      .flush_req          (flush_req),
      .flush_done         (flush_done),
      .busy               (busy)
`ifdef GSHARE_TRAIN_STATS_EN
      ,
      .stat_updates       (stat_updates),
      .stat_mispredicts   (stat_mispredicts)
`endif
   );

   task automatic set_in0(input logic v, input logic t, input logic m, input logic [6:0] h, input logic [6:0] p);
      in0_valid = v; in0_taken = t; in0_mispredicted = m; in0_history = h; in0_pc = p;
   endtask

   task automatic set_in1(input logic v, input logic t, input logic m, input logic [6:0] h, input logic [6:0] p);
      in1_valid = v; in1_taken = t; in1_mispredicted = m; in1_history = h; in1_pc = p;
   endtask

   // Records accepted requests, advances one clock, flags a freshly loaded output.
   task automatic step();
      bit adv_prev;
      adv_prev = !train_valid || !train_stall;
      if (in0_valid && in0_ready) exp_q.push_back({in0_taken, in0_mispredicted, in0_history, in0_pc});
      if (in1_valid && in1_ready) exp_q.push_back({in1_taken, in1_mispredicted, in1_history, in1_pc});
      @(posedge clk);
      #1;
      new_item = adv_prev && train_valid;
   endtask

   task automatic test_reset();
      areset = 1'b1; train_stall = 1'b0; flush_req = 1'b0;
      set_in0(0, 0, 0, 7'h0, 7'h0);
      set_in1(0, 0, 0, 7'h0, 7'h0);
      repeat (3) @(posedge clk);
      #1 areset = 1'b0;
      n_checks++; if (train_valid !== 1'b0) begin n_fail++; $display("FAIL reset_train_valid: got %b expected 0", train_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
      n_checks++; if (out_word !== 16'h0000) begin n_fail++; $display("FAIL reset_train_data: got %h expected 0000", out_word); end
      n_checks++; if ({in0_ready, in1_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b expected 11", {in0_ready, in1_ready}); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      set_in0(1, 1, 0, 7'h05, 7'h12);
      step();
      set_in0(0, 0, 0, 7'h0, 7'h0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
      n_checks++; if (train_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", train_valid); end
      step();
      n_checks++; if (train_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", train_valid); end
      n_checks++; if (out_word !== 16'h8292) begin n_fail++; $display("FAIL single_data: got %h expected 8292", out_word); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      step();
      n_checks++; if (train_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_fall: got %b expected 0", train_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
      $display("test_single done");
   endtask

   task automatic test_stream();
      int issued = 0;
      for (int c = 0; c < 15; c++) begin
         if (c < 3) begin
            set_in0(1, c[0], 1'b0, 7'(c), 7'(32 + 2*c));
            set_in1(1, !c[0], 1'b1, 7'(100 - c), 7'(33 + 2*c));
         end else begin
            set_in0(0, 0, 0, 7'h0, 7'h0);
            set_in1(0, 0, 0, 7'h0, 7'h0);
         end
         if (c < 3) begin
            n_checks++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in0_ready c=%0d: got %b expected 1", c, in0_ready); end
            n_checks++; if (in1_ready !== (c < 2)) begin n_fail++; $display("FAIL stream_in1_ready c=%0d: got %b expected %b", c, in1_ready, (c < 2)); end
         end
         step();
         if (new_item) begin
            issued++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL stream_order #%0d: got %h expected %h", issued, out_word, exp_w); end
            n_checks++; if (train_pc !== 7'(32 + issued - 1)) begin n_fail++; $display("FAIL stream_pc #%0d: got %h expected %h", issued, train_pc, 7'(32 + issued - 1)); end
         end
      end
      n_checks++; if (issued !== 5) begin n_fail++; $display("FAIL stream_count: got %0d expected 5", issued); end
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got %b expected 0", busy); end
      $display("test_stream done, %0d issued", issued);
   endtask

   task automatic test_stall_fill();
      int issued = 0;
      train_stall = 1'b1;
      for (int c = 0; c < 6; c++) begin
         set_in0(1, 1'b1, 1'b0, 7'(c), 7'(64 + 2*c));
         set_in1(1, 1'b0, 1'b1, 7'(127 - c), 7'(65 + 2*c));
         n_checks++; if (in0_ready !== (c < 3)) begin n_fail++; $display("FAIL fill_in0_ready c=%0d: got %b expected %b", c, in0_ready, (c < 3)); end
         n_checks++; if (in1_ready !== (c < 2)) begin n_fail++; $display("FAIL fill_in1_ready c=%0d: got %b expected %b", c, in1_ready, (c < 2)); end
         if (c >= 2) begin
            n_checks++; if (train_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c=%0d: got %b expected 1", c, train_valid); end
            n_checks++; if (out_word !== 16'h8040) begin n_fail++; $display("FAIL stall_hold c=%0d: got %h expected 8040", c, out_word); end
         end
         step();
         if (new_item) begin
            issued++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL fill_order #%0d: got %h expected %h", issued, out_word, exp_w); end
         end
      end
      set_in0(0, 0, 0, 7'h0, 7'h0);
      set_in1(0, 0, 0, 7'h0, 7'h0);
      train_stall = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (new_item) begin
            issued++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL fill_order #%0d: got %h expected %h", issued, out_word, exp_w); end
            n_checks++; if (train_pc !== 7'(64 + issued - 1)) begin n_fail++; $display("FAIL fill_pc #%0d: got %h expected %h", issued, train_pc, 7'(64 + issued - 1)); end
         end
      end
      n_checks++; if (issued !== 5) begin n_fail++; $display("FAIL fill_count: got %0d expected 5", issued); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle: got %b expected 0", busy); end
      $display("test_stall_fill done, %0d issued", issued);
   endtask

   // rel = first cycle with the stall released; flush is requested in cycle 2.
   task automatic test_flush(input int rel);
      int issued = 0;
      int dones  = 0;
      for (int c = 0; c < rel + 6; c++) begin
         if (c == 0) begin
            set_in0(1, 1'b0, 1'b0, 7'h0A, 7'h50);
            set_in1(1, 1'b1, 1'b0, 7'h0B, 7'h51);
         end else if (c == 1) begin
            set_in0(1, 1'b1, 1'b1, 7'h0C, 7'h52);
            set_in1(0, 0, 0, 7'h0, 7'h0);
         end else begin
            set_in0(0, 0, 0, 7'h0, 7'h0);
            set_in1(0, 0, 0, 7'h0, 7'h0);
         end
         flush_req   = (c == 2);
         train_stall = (c < rel);
         n_checks++; if (in0_ready !== !(c >= 3 && c <= rel + 3)) begin n_fail++; $display("FAIL flush%0d_in0_ready c=%0d: got %b expected %b", rel, c, in0_ready, !(c >= 3 && c <= rel + 3)); end
         n_checks++; if (in1_ready !== !(c >= 3 && c <= rel + 3)) begin n_fail++; $display("FAIL flush%0d_in1_ready c=%0d: got %b expected %b", rel, c, in1_ready, !(c >= 3 && c <= rel + 3)); end
         n_checks++; if (flush_done !== (c == rel + 3)) begin n_fail++; $display("FAIL flush%0d_done c=%0d: got %b expected %b", rel, c, flush_done, (c == rel + 3)); end
         if (flush_done === 1'b1) dones++;
         step();
         if (new_item) begin
            issued++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL flush%0d_order #%0d: got %h expected %h", rel, issued, out_word, exp_w); end
            n_checks++; if (train_pc !== 7'(80 + issued - 1)) begin n_fail++; $display("FAIL flush%0d_pc #%0d: got %h expected %h", rel, issued, train_pc, 7'(80 + issued - 1)); end
         end
      end
      train_stall = 1'b0;
      n_checks++; if (issued !== 3) begin n_fail++; $display("FAIL flush%0d_count: got %0d expected 3", rel, issued); end
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL flush%0d_pulses: got %0d expected 1", rel, dones); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush%0d_idle: got %b expected 0", rel, busy); end
      $display("test_flush rel=%0d done, %0d issued, %0d done pulses", rel, issued, dones);
   endtask

   task automatic test_reset_midop();
      train_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         set_in0(1, 1'b1, 1'b0, 7'h01, 7'(96 + 2*c));
         set_in1(1, 1'b1, 1'b0, 7'h02, 7'(97 + 2*c));
         step();
      end
      set_in0(0, 0, 0, 7'h0, 7'h0);
      set_in1(0, 0, 0, 7'h0, 7'h0);
      n_checks++; if (train_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pre_valid: got %b expected 1", train_valid); end
      n_checks++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL midop_pre_full: got %b expected 0", in0_ready); end
      #2 areset = 1'b1;
      #1;
      n_checks++; if (train_valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset_valid: got %b expected 0", train_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy: got %b expected 0", busy); end
      exp_q.delete();
      #1 areset = 1'b0;
      train_stall = 1'b0;
      @(posedge clk);
      #1;
      set_in0(1, 1'b0, 1'b1, 7'h11, 7'h33);
      step();
      set_in0(0, 0, 0, 7'h0, 7'h0);
      step();
      n_checks++; if (train_valid !== 1'b1) begin n_fail++; $display("FAIL midop_post_valid: got %b expected 1", train_valid); end
      n_checks++; if (out_word !== 16'h48B3) begin n_fail++; $display("FAIL midop_post_data: got %h expected 48b3", out_word); end
      exp_q.delete();
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_post_idle: got %b expected 0", busy); end
      $display("test_reset_midop done");
   endtask

`ifdef GSHARE_TRAIN_STATS_EN
   task automatic test_stats();
      #2 areset = 1'b1;
      #2 areset = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         set_in0(1, 1'b1, (c == 2 || c == 5 || c == 7), 7'h00, 7'(c));
         step();
      end
      set_in0(0, 0, 0, 7'h0, 7'h0);
      repeat (4) step();
      n_checks++; if (stat_updates !== 16'd10) begin n_fail++; $display("FAIL stats_updates: got %0d expected 10", stat_updates); end
      n_checks++; if (stat_mispredicts !== 16'd3) begin n_fail++; $display("FAIL stats_mispredicts: got %0d expected 3", stat_mispredicts); end
      force dut.stat_updates_q = 16'hFFFF;
      force dut.stat_mispredicts_q = 16'hFFFF;
      #1;
      release dut.stat_updates_q;
      release dut.stat_mispredicts_q;
      set_in0(1, 1'b0, 1'b1, 7'h00, 7'h7F);
      step();
      set_in0(0, 0, 0, 7'h0, 7'h0);
      repeat (4) step();
      n_checks++; if (stat_updates !== 16'hFFFF) begin n_fail++; $display("FAIL stats_updates_sat: got %h expected ffff", stat_updates); end
      n_checks++; if (stat_mispredicts !== 16'hFFFF) begin n_fail++; $display("FAIL stats_mispredicts_sat: got %h expected ffff", stat_mispredicts); end
      exp_q.delete();
      $display("test_stats done");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_stall_fill();
      test_flush(2);
      test_flush(6);
      test_reset_midop();
`ifdef GSHARE_TRAIN_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
